// File: rtl/gamepad_scan.sv
// Serial game-pad reader: N_PADS pads sharing latch/clock, N_BITS per pad.
// Optional macro GAMEPAD_PRESENT_EN adds per-pad presence detection.
module gamepad_scan #(
  parameter int N_PADS      = 1,
  parameter int N_BITS      = 12,
  parameter int CLK_DIV     = 6,
  parameter int POLL_CYCLES = 16666
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     auto_en,
  input  logic [N_PADS-1:0]        game_data,
  output logic                     game_latch,
  output logic                     game_clk,
  output logic [N_PADS*N_BITS-1:0] buttons,
  output logic                     busy,
`ifdef GAMEPAD_PRESENT_EN
  output logic [N_PADS-1:0]        present,
`endif
  output logic                     valid
);

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(N_BITS);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [DW-1:0] LATCH_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] HALF_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETTLE, S_CLK_LO, S_CLK_HI, S_DONE
  } state_t;

  state_t                     state;
  logic [DW-1:0]              div_cnt;
  logic [BW-1:0]              bit_idx;
  logic [PW-1:0]              poll_cnt;
  logic [N_PADS-1:0]          sync1, sync2;
  logic [N_PADS*N_BITS-1:0]   shadow, sampled, loaded;
  logic [N_PADS-1:0]          pad_present;
  logic                       trigger;

  assign trigger = (state == S_IDLE) &&
                   (start || (auto_en && (poll_cnt == POLL_LAST)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= game_data;
      sync2 <= sync1;
    end
  end

  // Shadow word with the current bit position overwritten by the live sample;
  // lets the final sample and the buttons load share one clock edge.
  always_comb begin
    sampled = shadow;
    for (int p = 0; p < N_PADS; p++)
      sampled[p*N_BITS + int'(bit_idx)] = ~sync2[p];
  end

`ifdef GAMEPAD_PRESENT_EN
  // A pad whose line read 0 on every sample is unplugged (pull-down).
  always_comb begin
    loaded      = sampled;
    pad_present = '0;
    for (int p = 0; p < N_PADS; p++) begin
      pad_present[p] = ~&sampled[p*N_BITS +: N_BITS];
      if (!pad_present[p]) loaded[p*N_BITS +: N_BITS] = '0;
    end
  end
`else
  always_comb begin
    loaded      = sampled;
    pad_present = '1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      bit_idx    <= '0;
      poll_cnt   <= '0;
      shadow     <= '0;
      buttons    <= '0;
      game_latch <= 1'b0;
      game_clk   <= 1'b1;
      busy       <= 1'b0;
      valid      <= 1'b0;
`ifdef GAMEPAD_PRESENT_EN
      present    <= '0;
`endif
    end else begin
      valid <= 1'b0;
      if (!auto_en || trigger) poll_cnt <= '0;
      else if (state == S_IDLE) poll_cnt <= poll_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (trigger) begin
            state      <= S_LATCH;
            game_latch <= 1'b1;
            busy       <= 1'b1;
            div_cnt    <= '0;
            bit_idx    <= '0;
          end
        end
        S_LATCH: begin
          if (div_cnt == LATCH_LAST) begin
            state      <= S_SETTLE;
            game_latch <= 1'b0;
            div_cnt    <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (div_cnt == HALF_LAST) begin
            shadow   <= sampled;
            bit_idx  <= BW'(1);
            state    <= S_CLK_LO;
            game_clk <= 1'b0;
            div_cnt  <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_CLK_LO: begin
          if (div_cnt == HALF_LAST) begin
            state    <= S_CLK_HI;
            game_clk <= 1'b1;
            div_cnt  <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_CLK_HI: begin
          if (div_cnt == HALF_LAST) begin
            shadow  <= sampled;
            div_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              state   <= S_DONE;
              valid   <= 1'b1;
              buttons <= loaded;
`ifdef GAMEPAD_PRESENT_EN
              present <= pad_present;
`endif
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              state    <= S_CLK_LO;
              game_clk <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamepad_scan.sv
// Directed bench for gamepad_scan: an 8-bit single pad and a 12-bit dual pad
// instance, each driven by a shift-register pad model.
module tb_gamepad_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Single 8-bit pad instance
  logic        start1 = 1'b0, auto1 = 1'b0;
  logic [0:0]  data1;
  logic        latch1, gclk1, busy1, valid1;
  logic [7:0]  btn1;
  logic [7:0]  pat1 = 8'hFF, sr1 = 8'hFF;
  logic        ovr_en = 1'b0, ovr_val = 1'b0;

  // Dual 12-bit pad instance
  logic        start2 = 1'b0, auto2 = 1'b0;
  logic [1:0]  data2;
  logic        latch2, gclk2, busy2, valid2;
  logic [23:0] btn2;
  logic [11:0] pat2a = 12'hFFF, pat2b = 12'hFFF, sr2a = 12'hFFF, sr2b = 12'hFFF;

`ifdef GAMEPAD_PRESENT_EN
  logic [0:0]  pres1;
  logic [1:0]  pres2;
`endif

  always @(posedge gclk1 or posedge latch1)
    if (latch1) sr1 <= pat1;
    else        sr1 <= {1'b1, sr1[7:1]};
  assign data1 = ovr_en ? ovr_val : sr1[0];

  always @(posedge gclk2 or posedge latch2)
    if (latch2) begin
      sr2a <= pat2a;
      sr2b <= pat2b;
    end else begin
      sr2a <= {1'b1, sr2a[11:1]};
      sr2b <= {1'b1, sr2b[11:1]};
    end
  assign data2 = {sr2b[0], sr2a[0]};

  gamepad_scan #(.N_PADS(1), .N_BITS(8), .CLK_DIV(3), .POLL_CYCLES(100)) u1 (
    .clk(clk), .rst(rst), .start(start1), .auto_en(auto1), .game_data(data1),
    .game_latch(latch1), .game_clk(gclk1), .buttons(btn1), .busy(busy1),
`ifdef GAMEPAD_PRESENT_EN
    .present(pres1),
`endif
    .valid(valid1));

  gamepad_scan #(.N_PADS(2), .N_BITS(12), .CLK_DIV(3), .POLL_CYCLES(100)) u2 (
    .clk(clk), .rst(rst), .start(start2), .auto_en(auto2), .game_data(data2),
    .game_latch(latch2), .game_clk(gclk2), .buttons(btn2), .busy(busy2),
`ifdef GAMEPAD_PRESENT_EN
    .present(pres2),
`endif
    .valid(valid2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse1();
    @(negedge clk);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
  endtask

  task automatic pulse2();
    @(negedge clk);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
  endtask

  // Runs until busy drops (bounded); cycle 0 is the first LATCH sample.
  task automatic run1(output int cyc, output int vcnt, output int vidx,
                      output int lat_n, output int fall_n);
    logic prev_clk;
    cyc = 0; vcnt = 0; vidx = -1; lat_n = 0; fall_n = 0; prev_clk = gclk1;
    while (busy1 && cyc < 400) begin
      if (valid1) begin
        vcnt++;
        if (vidx < 0) vidx = cyc;
      end
      if (latch1) lat_n++;
      if (prev_clk && !gclk1) fall_n++;
      prev_clk = gclk1;
      step();
      cyc++;
    end
  endtask

  task automatic run2(output int cyc, output int vcnt, output int vidx);
    cyc = 0; vcnt = 0; vidx = -1;
    while (busy2 && cyc < 400) begin
      if (valid2) begin
        vcnt++;
        if (vidx < 0) vidx = cyc;
      end
      step();
      cyc++;
    end
  endtask

  initial begin
    int cyc, vcnt, vidx, lat_n, fall_n, gap;

    // Reset state
    repeat (3) step();
    check("rst_latch", latch1, 0);
    check("rst_gclk", gclk1, 1);
    check("rst_busy", busy1, 0);
    check("rst_valid", valid1, 0);
    check("rst_btn1", btn1, 0);
    check("rst_btn2", btn2, 0);
`ifdef GAMEPAD_PRESENT_EN
    check("rst_present", pres2, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();

    // Basic 8-bit scan
    pat1 = 8'b1011_0110;
    pulse1();
    check("t1_busy_next", busy1, 1);
    check("t1_latch_next", latch1, 1);
    run1(cyc, vcnt, vidx, lat_n, fall_n);
    check("t1_latch_cycles", lat_n, 6);
    check("t1_clk_pulses", fall_n, 7);
    check("t1_valid_at", vidx, 51);
    check("t1_valid_cnt", vcnt, 1);
    check("t1_busy_end", cyc, 52);
    check("t1_buttons", btn1, 8'b0100_1001);
    check("t1_idle_gclk", gclk1, 1);

    // Glitch on an already-sampled bit during CLK_LO of bit 1
    pat1 = 8'h3C;
    pulse1();
    repeat (9) step();
    ovr_val = ~sr1[0];
    ovr_en  = 1'b1;
    repeat (2) step();
    ovr_en  = 1'b0;
    check("t6_btn_mid", btn1, 8'h49);
    run1(cyc, vcnt, vidx, lat_n, fall_n);
    check("t6_valid_cnt", vcnt, 1);
    check("t6_buttons", btn1, 8'hC3);

    // Auto poll: 100 idle cycles between scans; start while busy ignored
    pat1 = 8'h00;
    @(negedge clk);
    auto1 = 1'b1;
    gap = 0;
    do begin
      step();
      gap++;
    end while (!busy1 && gap < 300);
    check("t3_first_gap", gap, 100);
    repeat (20) step();
    pulse1();
    run1(cyc, vcnt, vidx, lat_n, fall_n);
    check("t3_scan_valid", vcnt, 1);
    check("t3_buttons", btn1, 8'hFF);
    gap = 0;
    while (!busy1 && gap < 300) begin
      step();
      gap++;
    end
    check("t3_second_gap", gap, 100);
    @(negedge clk);
    auto1 = 1'b0;
    step();
    run1(cyc, vcnt, vidx, lat_n, fall_n);
    check("t3_third_valid", vcnt, 1);
    repeat (120) step();
    check("t3_no_extra_scan", busy1, 0);

    // Dual 12-bit pads
    pat2a = 12'hFFE;
    pat2b = 12'h7FF;
    pulse2();
    run2(cyc, vcnt, vidx);
    check("t2_valid_at", vidx, 75);
    check("t2_valid_cnt", vcnt, 1);
    check("t2_buttons", btn2, 24'h800001);

    // Asynchronous reset mid-scan
    pulse2();
    repeat (20) step();
    check("t4_busy_before", busy2, 1);
    rst = 1'b1;
    #1;
    check("t4_latch", latch2, 0);
    check("t4_gclk", gclk2, 1);
    check("t4_busy", busy2, 0);
    check("t4_valid", valid2, 0);
    check("t4_btn2", btn2, 0);
    check("t4_btn1", btn1, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();
    pat2a = 12'hA5A;
    pat2b = 12'h3C3;
    pulse2();
    run2(cyc, vcnt, vidx);
    check("t4_rescan_at", vidx, 75);
    check("t4_rescan_btn", btn2, 24'hC3C5A5);

    // Pad 1 line held low (unplugged)
    pat2a = 12'hFFE;
    pat2b = 12'h000;
    pulse2();
    run2(cyc, vcnt, vidx);
`ifdef GAMEPAD_PRESENT_EN
    check("t5_present", pres2, 2'b01);
    check("t5_buttons", btn2, 24'h000001);
`else
    check("t5_buttons_raw", btn2, 24'hFFF001);
`endif
    pat2b = 12'hFFF;
    pulse2();
    run2(cyc, vcnt, vidx);
`ifdef GAMEPAD_PRESENT_EN
    check("t5_present_back", pres2, 2'b11);
`endif
    check("t5_buttons_back", btn2, 24'h000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
